// File: rtl/ledger_arbiter.sv
// Round-robin arbiter granting NUM_REQ ATM sessions atomic read-modify-write
// access to a shared account-balance store.
module ledger_arbiter #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned BAL_W    = 20,
   parameter int unsigned ACCT_W   = 4,
   parameter int unsigned INIT_BAL = 1000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [2*NUM_REQ-1:0]      req_op,
   input  logic [ACCT_W*NUM_REQ-1:0] req_acct,
   input  logic [BAL_W*NUM_REQ-1:0]  req_value,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [BAL_W-1:0]          rsp_balance,
   output logic                      rsp_error,
   output logic                      busy
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);
   localparam int unsigned DEPTH = 2 ** ACCT_W;

   localparam logic [1:0] OP_WD  = 2'b00;
   localparam logic [1:0] OP_DEP = 2'b01;
   localparam logic [1:0] OP_INQ = 2'b10;

   typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, RESP} state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [PTR_W-1:0]    win_q, win_d;
   logic [1:0]          op_q, op_d;
   logic [ACCT_W-1:0]   acct_q, acct_d;
   logic [BAL_W-1:0]    val_q, val_d;
   logic [BAL_W-1:0]    bal_q, bal_d;
   logic [BAL_W-1:0]    newbal_q, newbal_d;
   logic                err_q, err_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [BAL_W-1:0]    rsp_bal_q, rsp_bal_d;
   logic                rsp_err_q, rsp_err_d;
   logic [BAL_W-1:0]    mem_q [DEPTH];
   logic                found;
   logic [BAL_W:0]      sum;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         win_q       <= '0;
         op_q        <= '0;
         acct_q      <= '0;
         val_q       <= '0;
         bal_q       <= '0;
         newbal_q    <= '0;
         err_q       <= 1'b0;
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_bal_q   <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         win_q       <= win_d;
         op_q        <= op_d;
         acct_q      <= acct_d;
         val_q       <= val_d;
         bal_q       <= bal_d;
         newbal_q    <= newbal_d;
         err_q       <= err_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_bal_q   <= rsp_bal_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Only successful withdraw/deposit commits; inquiry and errored ops leave the store untouched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= BAL_W'(INIT_BAL);
         end
      end else if (state_q == WRITE && !err_q && op_q != OP_INQ) begin
         mem_q[acct_q] <= newbal_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      win_d       = win_q;
      op_d        = op_q;
      acct_d      = acct_q;
      val_d       = val_q;
      bal_d       = bal_q;
      newbal_d    = newbal_q;
      err_d       = err_q;
      gnt_d       = gnt_q;
      rsp_valid_d = '0;
      rsp_bal_d   = rsp_bal_q;
      rsp_err_d   = rsp_err_q;
      found       = 1'b0;
      sum         = {1'b0, bal_q} + {1'b0, val_q};

      case (state_q)
         IDLE: begin
            // Two passes give the wrap-around scan: ptr..NUM_REQ-1, then 0..ptr-1.
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
               if (!found && j >= 32'(ptr_q) && req[j]) begin
                  found = 1'b1;
                  win_d = PTR_W'(j);
               end
            end
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
               if (!found && req[j]) begin
                  found = 1'b1;
                  win_d = PTR_W'(j);
               end
            end
            if (found) begin
               op_d         = req_op[2*win_d +: 2];
               acct_d       = req_acct[ACCT_W*win_d +: ACCT_W];
               val_d        = req_value[BAL_W*win_d +: BAL_W];
               gnt_d        = '0;
               gnt_d[win_d] = 1'b1;
               state_d      = READ;
            end
         end
         READ: begin
            bal_d   = mem_q[acct_q];
            state_d = EXEC;
         end
         EXEC: begin
            err_d    = 1'b0;
            newbal_d = bal_q;
            case (op_q)
               OP_WD: begin
                  if (val_q > bal_q) err_d = 1'b1;
                  else               newbal_d = bal_q - val_q;
               end
               OP_DEP: begin
                  if (sum[BAL_W]) err_d = 1'b1;
                  else            newbal_d = sum[BAL_W-1:0];
               end
               OP_INQ:  err_d = 1'b0;
               default: err_d = 1'b1;
            endcase
            state_d = WRITE;
         end
         WRITE: begin
            rsp_valid_d[win_q] = 1'b1;
            rsp_bal_d          = newbal_q;
            rsp_err_d          = err_q;
            state_d            = RESP;
         end
         RESP: begin
            gnt_d   = '0;
            ptr_d   = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign gnt         = gnt_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_balance = rsp_bal_q;
   assign rsp_error   = rsp_err_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ledger_arbiter.sv
// Self-checking bench for ledger_arbiter: directed table, corner sequences,
// and randomized multi-requester traffic against an account-level model.
module tb_ledger_arbiter;
   localparam int N  = 4;
   localparam int BW = 20;
   localparam int AW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req;
   logic [2*N-1:0]  req_op;
   logic [AW*N-1:0] req_acct;
   logic [BW*N-1:0] req_value;
   logic [N-1:0]    gnt, rsp_valid;
   logic [BW-1:0]   rsp_balance;
   logic            rsp_error, busy;

   ledger_arbiter #(.NUM_REQ(N), .BAL_W(BW), .ACCT_W(AW), .INIT_BAL(1000)) dut (
      .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_acct(req_acct),
      .req_value(req_value), .gnt(gnt), .rsp_valid(rsp_valid),
      .rsp_balance(rsp_balance), .rsp_error(rsp_error), .busy(busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int unsigned mbal [16];
   int mptr;

   typedef struct {
      int          who;
      int          op;
      int          acct;
      int unsigned val;
      int unsigned eb;
      bit          ee;
   } vec_t;
   vec_t tbl [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mbal[i] = 1000;
      mptr = 0;
   endtask

   // Account-level semantics: returns resulting balance and error, commits on success.
   function automatic void model_op(input int op, input int acct, input int unsigned val,
                                    output int unsigned b, output bit e);
      longint s;
      b = mbal[acct];
      e = 1'b0;
      case (op)
         0: if (val > b) e = 1'b1; else b = b - val;
         1: begin
            s = longint'(b) + longint'(val);
            if (s >= (64'd1 << BW)) e = 1'b1; else b = int'(s);
         end
         2: ;
         default: e = 1'b1;
      endcase
      if (!e) mbal[acct] = b;
   endfunction

   task automatic set_req(input int i, input int op, input int acct, input int unsigned val);
      req[i]                = 1'b1;
      req_op[2*i +: 2]      = 2'(op);
      req_acct[AW*i +: AW]  = AW'(acct);
      req_value[BW*i +: BW] = BW'(val);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      req = '0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic wait_rsp(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (rsp_valid == '0 && cyc < 20);
   endtask

   // Single requester transaction from IDLE; returns in the following IDLE cycle.
   task automatic txn(input int who, input int op, input int acct, input int unsigned val,
                      input int unsigned eb, input bit ee, input string nm);
      int cyc;
      int unsigned b;
      bit e;
      @(negedge clk);
      set_req(who, op, acct, val);
      @(posedge clk); #1;
      chk({nm, " gnt"}, 32'(gnt), 32'(1 << who));
      cyc = 1;
      while (rsp_valid == '0 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({nm, " latency"}, cyc, 4);
      chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'(1 << who));
      chk({nm, " balance"}, 32'(rsp_balance), eb);
      chk({nm, " error"}, 32'(rsp_error), 32'(ee));
      req[who] = 1'b0;
      model_op(op, acct, val, b, e);
      mptr = (who + 1) % N;
      @(posedge clk); #1;
      chk({nm, " idle"}, 32'(busy), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] eg [5];
      logic [N-1:0] gl [5];
      int           tm [5];
      logic [N-1:0] prev, pend;
      int           n, cyc, w;
      int           rops [N];
      int           raccts [N];
      int unsigned  rvals [N];
      int unsigned  b;
      bit           e;

      tbl[0] = '{0, 2, 3, 0,                1000,    1'b0};
      tbl[1] = '{1, 0, 5, 300,              700,     1'b0};
      tbl[2] = '{1, 2, 5, 0,                700,     1'b0};
      tbl[3] = '{1, 0, 5, 701,              700,     1'b1};
      tbl[4] = '{1, 0, 5, 700,              0,       1'b0};
      tbl[5] = '{2, 1, 2, (1 << 20) - 1000, 1000,    1'b1};
      tbl[6] = '{2, 1, 2, (1 << 20) - 1001, 1048575, 1'b0};
      tbl[7] = '{3, 3, 4, 5,                1000,    1'b1};
      tbl[8] = '{3, 2, 4, 0,                1000,    1'b0};
      eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

      rst = 1'b0;
      req = '0; req_op = '0; req_acct = '0; req_value = '0;
      model_reset();
      #3;
      chk("reset gnt", 32'(gnt), 0);
      chk("reset rsp_valid", 32'(rsp_valid), 0);
      chk("reset rsp_balance", 32'(rsp_balance), 0);
      chk("reset rsp_error", 32'(rsp_error), 0);
      chk("reset busy", 32'(busy), 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;

      for (int k = 0; k < 9; k++)
         txn(tbl[k].who, tbl[k].op, tbl[k].acct, tbl[k].val, tbl[k].eb, tbl[k].ee,
             $sformatf("vec%0d", k));

      // All four requesting continuously: rotating grants, 5 cycles apart.
      do_reset();
      @(negedge clk);
      for (int i = 0; i < N; i++) set_req(i, 2, i, 0);
      prev = '0; n = 0;
      for (int c = 0; c < 40 && n < 5; c++) begin
         @(posedge clk); #1;
         if (gnt != '0 && prev == '0) begin
            gl[n] = gnt;
            tm[n] = c;
            n++;
         end
         prev = gnt;
      end
      chk("rr grant count", n, 5);
      for (int k = 0; k < 5 && k < n; k++) begin
         chk($sformatf("rr grant%0d", k), 32'(gl[k]), 32'(eg[k]));
         if (k > 0) chk($sformatf("rr spacing%0d", k), tm[k] - tm[k-1], 5);
      end

      // Same account, same cycle: serialised, second sees first's result.
      do_reset();
      @(negedge clk);
      set_req(0, 0, 7, 600);
      set_req(2, 0, 7, 600);
      wait_rsp(cyc);
      chk("same-acct first valid", 32'(rsp_valid), 32'(4'b0001));
      chk("same-acct first bal", 32'(rsp_balance), 400);
      chk("same-acct first err", 32'(rsp_error), 0);
      req[0] = 1'b0;
      wait_rsp(cyc);
      chk("same-acct second valid", 32'(rsp_valid), 32'(4'b0100));
      chk("same-acct second bal", 32'(rsp_balance), 400);
      chk("same-acct second err", 32'(rsp_error), 1);
      req[2] = 1'b0;
      model_op(0, 7, 600, b, e);
      model_op(0, 7, 600, b, e);
      mptr = 3;
      @(posedge clk); #1;

      // Reset during EXEC aborts the deposit.
      @(negedge clk);
      set_req(0, 1, 1, 50);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("abort busy before reset", 32'(busy), 1);
      #2 rst = 1'b0;
      #1;
      chk("abort gnt", 32'(gnt), 0);
      chk("abort busy", 32'(busy), 0);
      chk("abort rsp_valid", 32'(rsp_valid), 0);
      chk("abort rsp_balance", 32'(rsp_balance), 0);
      chk("abort rsp_error", 32'(rsp_error), 0);
      req = '0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      txn(0, 2, 1, 0, 1000, 1'b0, "abort inquiry");

      // Random multi-requester traffic against the model.
      for (int it = 0; it < 60; it++) begin
         @(negedge clk);
         pend = N'($urandom_range(15, 1));
         for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
               rops[i]   = int'($urandom_range(3, 0));
               raccts[i] = int'($urandom_range(3, 0));
               rvals[i]  = ($urandom_range(3, 0) == 0) ? $urandom_range((1 << 20) - 1, 0)
                                                       : $urandom_range(1200, 0);
               set_req(i, rops[i], raccts[i], rvals[i]);
            end
         end
         while (pend != '0) begin
            w = -1;
            for (int k = 0; k < N; k++)
               if (w < 0 && pend[(mptr + k) % N]) w = (mptr + k) % N;
            wait_rsp(cyc);
            model_op(rops[w], raccts[w], rvals[w], b, e);
            chk($sformatf("rnd%0d valid", it), 32'(rsp_valid), 32'(1 << w));
            chk($sformatf("rnd%0d gnt", it), 32'(gnt), 32'(1 << w));
            chk($sformatf("rnd%0d bal", it), 32'(rsp_balance), b);
            chk($sformatf("rnd%0d err", it), 32'(rsp_error), 32'(e));
            req[w]  = 1'b0;
            pend[w] = 1'b0;
            mptr    = (w + 1) % N;
         end
         @(posedge clk); #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
